// File: rtl/cirno_pkg.sv
// rtl/cirno_pkg.sv - shared types and constants for the control unit slice
//
// Purpose: opcode encodings, FSM state type, ALU/write-select enums, width
// constants and the decoded control bundle passed from inst_decoder to
// control_unit.
// Ports: none (package).
package cirno_pkg;

   localparam int INST_WIDTH = 9;
   localparam int DATA_WIDTH = 8;
   localparam int TGT_WIDTH  = 8;
   localparam int IMM_WIDTH  = 6;

   localparam logic [2:0] OP_SYS  = 3'b000;
   localparam logic [2:0] OP_ALU  = 3'b001;
   localparam logic [2:0] OP_MOVL = 3'b100;
   localparam logic [2:0] OP_MOVH = 3'b101;
   localparam logic [2:0] OP_BR   = 3'b110;
   localparam logic [2:0] OP_BRI  = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_HALT   = 3'd4
   } ctrl_state_t;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_AND = 2'd2,
      ALU_XOR = 2'd3
   } alu_op_t;

   typedef enum logic [1:0] {
      WSEL_ALU = 2'd0,
      WSEL_LO  = 2'd1,
      WSEL_HI  = 2'd2
   } wsel_t;

   // Everything the EXEC cycle drives, decoded from the instruction register.
   typedef struct packed {
      logic                 fetch_en;
      logic                 branch;
      logic                 branchi;
      logic [TGT_WIDTH-1:0] target;
      logic [IMM_WIDTH-1:0] immediate;
      logic [1:0]           raddr_a;
      logic [1:0]           raddr_b;
      logic                 we;
      logic [1:0]           waddr;
      wsel_t                wsel;
      logic [3:0]           imm;
      alu_op_t              alu_op;
      logic                 halt;
   } ctrl_t;

endpackage

// File: rtl/inst_decoder.sv
// rtl/inst_decoder.sv - combinational instruction register to control bundle
//
// Purpose: decodes the latched instruction into register-file, ALU and
// fetch controls for the EXEC cycle. Illegal encodings decode as nop.
// Ports:
//   ir          in   latched instruction word
//   rf_rdata_a  in   register-file port A data (branch target source)
//   zero_flag   in   ALU zero flag (bz condition)
//   ctl         out  decoded control bundle
module inst_decoder
   import cirno_pkg::*;
(
   input  logic [INST_WIDTH-1:0] ir,
   input  logic [DATA_WIDTH-1:0] rf_rdata_a,
   input  logic                  zero_flag,
   output ctrl_t                 ctl
);

   always_comb begin
      ctl          = '0;
      ctl.fetch_en = 1'b1;
      case (ir[8:6])
         OP_SYS: begin
            if (ir[5:0] == 6'd1) begin
               ctl.fetch_en = 1'b0;
               ctl.halt     = 1'b1;
            end
         end
         OP_ALU: begin
            ctl.alu_op  = alu_op_t'(ir[5:4]);
            ctl.waddr   = ir[3:2];
            ctl.raddr_a = ir[1:0];
            ctl.raddr_b = ir[3:2];
            ctl.we      = 1'b1;
            ctl.wsel    = WSEL_ALU;
         end
         OP_MOVL: begin
            ctl.waddr = ir[5:4];
            ctl.wsel  = WSEL_LO;
            ctl.imm   = ir[3:0];
            ctl.we    = 1'b1;
         end
         OP_MOVH: begin
            ctl.waddr = ir[5:4];
            ctl.wsel  = WSEL_HI;
            ctl.imm   = ir[3:0];
            ctl.we    = 1'b1;
         end
         OP_BR: begin
            // Only 110_000_x_ss is a branch; ir[2] selects conditional bz.
            if (ir[5:3] == 3'b000) begin
               ctl.raddr_a = ir[1:0];
               ctl.target  = rf_rdata_a;
               ctl.branch  = ir[2] ? zero_flag : 1'b1;
            end
         end
         OP_BRI: begin
            ctl.branchi   = 1'b1;
            ctl.immediate = ir[5:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle sequencer driving fetch_unit, register file and ALU
//
// Purpose: LOAD -> DECODE -> EXEC loop, two cycles per instruction after a
// one-cycle load. Optional retire counter guarded by CTRL_RETIRE_COUNT_EN.
// Ports:
//   clk, reset                clock, synchronous active-high reset
//   start                     begin execution (accepted in IDLE/HALT)
//   inst                      instruction word from fetch_unit
//   rf_rdata_a, zero_flag     register-file data A, ALU zero flag
//   fetch_unit_en, init,
//   branch, branchi,
//   target, immediate         fetch_unit controls
//   rf_raddr_a/b, rf_we,
//   rf_waddr, rf_wsel, rf_imm register-file controls
//   alu_op                    ALU operation
//   busy, halted              status
//   retired                   retired instruction count (CTRL_RETIRE_COUNT_EN)
module control_unit
   import cirno_pkg::*;
#(
   parameter int INST_W = INST_WIDTH,
   parameter int DATA_W = DATA_WIDTH,
   parameter int TGT_W  = TGT_WIDTH,
   parameter int IMM_W  = IMM_WIDTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [INST_W-1:0] inst,
   input  logic [DATA_W-1:0] rf_rdata_a,
   input  logic              zero_flag,
   output logic              fetch_unit_en,
   output logic              init,
   output logic              branch,
   output logic              branchi,
   output logic [TGT_W-1:0]  target,
   output logic [IMM_W-1:0]  immediate,
   output logic [1:0]        rf_raddr_a,
   output logic [1:0]        rf_raddr_b,
   output logic              rf_we,
   output logic [1:0]        rf_waddr,
   output logic [1:0]        rf_wsel,
   output logic [3:0]        rf_imm,
   output logic [1:0]        alu_op,
   output logic              busy,
   output logic              halted
`ifdef CTRL_RETIRE_COUNT_EN
   ,
   output logic [15:0]       retired
`endif
);

   ctrl_state_t       state;
   logic [INST_W-1:0] ir;
   ctrl_t             dec;

   inst_decoder u_dec (
      .ir         (ir),
      .rf_rdata_a (rf_rdata_a),
      .zero_flag  (zero_flag),
      .ctl        (dec)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         ir    <= '0;
`ifdef CTRL_RETIRE_COUNT_EN
         retired <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_HALT: begin
               if (start) begin
                  state <= ST_LOAD;
`ifdef CTRL_RETIRE_COUNT_EN
                  retired <= '0;
`endif
               end
            end
            ST_LOAD:   state <= ST_DECODE;
            ST_DECODE: begin
               ir    <= inst;
               state <= ST_EXEC;
            end
            ST_EXEC: begin
               state <= dec.halt ? ST_HALT : ST_DECODE;
`ifdef CTRL_RETIRE_COUNT_EN
               retired <= retired + 16'd1;
`endif
            end
            default:   state <= ST_IDLE;
         endcase
      end
   end

   // Control outputs are masked while reset is high so an instruction cut
   // short by reset never commits a register write or a pc update.
   always_comb begin
      fetch_unit_en = 1'b0;
      init          = 1'b0;
      branch        = 1'b0;
      branchi       = 1'b0;
      target        = '0;
      immediate     = '0;
      rf_raddr_a    = 2'd0;
      rf_raddr_b    = 2'd0;
      rf_we         = 1'b0;
      rf_waddr      = 2'd0;
      rf_wsel       = 2'd0;
      rf_imm        = 4'd0;
      alu_op        = 2'd0;
      if (!reset) begin
         case (state)
            ST_LOAD: begin
               fetch_unit_en = 1'b1;
               init          = 1'b1;
            end
            ST_DECODE: begin
               // Early read so register data is valid during EXEC.
               rf_raddr_a = inst[1:0];
               rf_raddr_b = inst[3:2];
            end
            ST_EXEC: begin
               fetch_unit_en = dec.fetch_en;
               branch        = dec.branch;
               branchi       = dec.branchi;
               target        = dec.target;
               immediate     = dec.immediate;
               rf_raddr_a    = dec.raddr_a;
               rf_raddr_b    = dec.raddr_b;
               rf_we         = dec.we;
               rf_waddr      = dec.waddr;
               rf_wsel       = dec.wsel;
               rf_imm        = dec.imm;
               alu_op        = dec.alu_op;
            end
            default: ;
         endcase
      end
   end

   assign busy   = (state == ST_LOAD) || (state == ST_DECODE) || (state == ST_EXEC);
   assign halted = (state == ST_HALT);

endmodule
